// File: rtl/stream_mux_rr.sv
// Registered N-to-1 valid/ready stream mux with static, round-robin and fixed-priority arbitration.
// One clock of latency. A stalled output holds its word and drops every in_ready; it refills on the same cycle it drains.
module stream_mux_rr #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mode,
    input  logic [SEL_W-1:0]          select,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_vld;
    logic [WIDTH-1:0] grant_dat;
    logic             load_en;

    assign load_en = !out_valid_q || out_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        case (mode)
            2'b01: begin
                // Walk offsets from farthest to nearest so the nearest valid channel after rr_ptr wins.
                for (int off = CHANNELS; off >= 1; off--) begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        if ((((int'(rr_ptr_q)) + off) % CHANNELS) == k && in_valid[k]) begin
                            grant_vld = 1'b1;
                            grant_idx = SEL_W'(k);
                        end
                    end
                end
            end
            2'b10: begin
                for (int k = CHANNELS - 1; k >= 0; k--) begin
                    if (in_valid[k]) begin
                        grant_vld = 1'b1;
                        grant_idx = SEL_W'(k);
                    end
                end
            end
            default: begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (select == SEL_W'(k) && in_valid[k]) begin
                        grant_vld = 1'b1;
                        grant_idx = SEL_W'(k);
                    end
                end
            end
        endcase
    end

    // Only the granted slice is ever routed, so X on other channels cannot leak through.
    always_comb begin
        grant_dat = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_idx == SEL_W'(k)) begin
                grant_dat = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            in_ready[k] = !reset && load_en && grant_vld && (grant_idx == SEL_W'(k));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            if (grant_vld) begin
                out_valid_d = 1'b1;
                out_data_d  = grant_dat;
                out_chan_d  = grant_idx;
                if (mode == 2'b01) begin
                    rr_ptr_d = grant_idx;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= SEL_W'(CHANNELS - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: reset, static, round-robin, priority, backpressure and reset-during-stall.
module tb_stream_mux_rr;

    logic        clk;
    logic        reset;
    logic [1:0]  mode;
    logic [1:0]  select;
    logic [19:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [4:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    stream_mux_rr #(.WIDTH(5), .CHANNELS(4), .SEL_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .select    (select),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        mode      = 2'b01;
        select    = 2'd0;
        in_data   = {5'h13, 5'h12, 5'h11, 5'h10};
        in_valid  = 4'b1111;
        out_ready = 1'b1;

        // 1: reset held two clocks with everything valid
        tick();
        chk("rst_in_ready0", in_ready, 4'b0000);
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 5'h00);
        chk("rst_out_chan", out_chan, 2'd0);
        chk("rst_in_ready1", in_ready, 4'b0000);
        reset = 1'b0;
        #1;
        chk("rst_rr_first", in_ready, 4'b0001);
        mode = 2'b10;
        #1;
        chk("rst_prio_first", in_ready, 4'b0001);
        mode = 2'b01;
        #1;

        // 3: round-robin, all valid, then alternate pair
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_chan", out_chan, i % 4);
            chk("rr_data", out_data, 16 + (i % 4));
            chk("rr_valid", out_valid, 1'b1);
        end
        in_valid = 4'b1010;
        #1;
        chk("rr_sparse_ready", in_ready, 4'b0010);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_sparse_chan", out_chan, (i % 2 == 0) ? 1 : 3);
        end

        // 2: static select with an undriven ungranted channel
        mode     = 2'b00;
        select   = 2'd2;
        in_valid = 4'b1111;
        in_data[4:0] = 5'bxxxxx;
        #1;
        chk("st_ready", in_ready, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_chan", out_chan, 2'd2);
            chk("st_data", out_data, 5'h12);
            chk("st_ready_hold", in_ready, 4'b0100);
        end
        select   = 2'd1;
        in_valid = 4'b1101;
        #1;
        chk("st_noval_ready", in_ready, 4'b0000);
        tick();
        chk("st_noval_drain", out_valid, 1'b0);
        in_data = {5'h13, 5'h12, 5'h11, 5'h10};

        // 4: fixed priority
        mode     = 2'b10;
        in_valid = 4'b1100;
        #1;
        chk("pr_ready", in_ready, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pr_chan", out_chan, 2'd2);
        end
        in_valid = 4'b1000;
        tick();
        chk("pr_only3", out_chan, 2'd3);
        in_valid = 4'b1100;
        tick();
        chk("pr_back2", out_chan, 2'd2);

        // 5: backpressure in round-robin; pointer must still be 3 from the rr phase
        mode     = 2'b01;
        in_valid = 4'b1111;
        #1;
        chk("bp_first_ready", in_ready, 4'b0001);
        tick();
        chk("bp_first_chan", out_chan, 2'd0);
        out_ready = 1'b0;
        #1;
        chk("bp_stall_ready", in_ready, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_chan", out_chan, 2'd0);
            chk("bp_hold_data", out_data, 5'h10);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_ready", in_ready, 4'b0000);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 4'b0010);
        tick();
        chk("bp_refill_chan", out_chan, 2'd1);
        chk("bp_refill_valid", out_valid, 1'b1);
        chk("bp_refill_data", out_data, 5'h11);

        // 6: reset while stalled
        out_ready = 1'b0;
        tick();
        chk("rs_stall_chan", out_chan, 2'd1);
        reset = 1'b1;
        tick();
        chk("rs_valid", out_valid, 1'b0);
        chk("rs_data", out_data, 5'h00);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rs_ptr_ready", in_ready, 4'b0001);
        tick();
        chk("rs_next_chan", out_chan, 2'd0);
        chk("rs_next_valid", out_valid, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
